// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and decode helper for the 7-segment scan driver.
//   Segment codes are active-low {g,f,e,d,c,b,a} for a common-anode display.
//   Digit indices name the scan slot of each BCD digit (0 = rightmost).
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [2:0] DIG_SEC_ONES  = 3'd0;
   localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
   localparam logic [2:0] DIG_MIN_ONES  = 3'd2;
   localparam logic [2:0] DIG_MIN_TENS  = 3'd3;
   localparam logic [2:0] DIG_HOUR_ONES = 3'd4;
   localparam logic [2:0] DIG_HOUR_TENS = 3'd5;

   // Non-decimal nibbles show a dash so a corrupted counter is visible.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
      logic [6:0] s;
      case (nibble)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: digit-advance prescaler. Counts 0..DIV-1 and wraps; tick is
// high for the single cycle the count sits at DIV-1. Held at 0 while en = 0.
//   clk  in   system clock
//   rst  in   synchronous reset, active-high
//   en   in   count enable
//   tick out  one-cycle pulse every DIV cycles
module scan_tick_gen #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes six BCD time digits onto a common-anode
// 7-segment display. All three fields are captured together at each frame wrap
// so a frame never mixes old and new time values.
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   en          in   display enable (0 blanks display, holds scan at digit 0)
//   hour_bcd    in   {tens, ones} BCD hours
//   min_bcd     in   {tens, ones} BCD minutes
//   sec_bcd     in   {tens, ones} BCD seconds
//   blink_mask  in   {hours, minutes, seconds} blink select (SEG7_SCAN_BLINK_EN only)
//   an          out  digit select, active-low, an[0] rightmost
//   seg         out  {g,f,e,d,c,b,a}, active-low
//   dp          out  decimal point, active-low
// Optional build macro: SEG7_SCAN_BLINK_EN adds blink_mask and BLINK_HZ.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int SCAN_HZ = 1000,
   parameter int LZB     = 1
`ifdef SEG7_SCAN_BLINK_EN
   ,
   parameter int BLINK_HZ = 2
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] hour_bcd,
   input  logic [7:0] min_bcd,
   input  logic [7:0] sec_bcd,
`ifdef SEG7_SCAN_BLINK_EN
   input  logic [2:0] blink_mask,
`endif
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int DIV = CLK_HZ / SCAN_HZ;

   logic        tick;
   logic [2:0]  idx;
   logic [23:0] snap;
   logic [3:0]  nib;
   logic [5:0]  an_nxt;
   logic [6:0]  seg_nxt;
   logic        dp_nxt;

   scan_tick_gen #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (tick)
   );

`ifdef SEG7_SCAN_BLINK_EN
   localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
   localparam int BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [BW-1:0] blink_cnt;
   logic          blink_phase;

   // Free-running regardless of en so blink cadence stays steady across gating.
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt   <= BW'(BLINK_DIV - 1);
         blink_phase <= 1'b0;
      end else if (blink_cnt == '0) begin
         blink_cnt   <= BW'(BLINK_DIV - 1);
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt - BW'(1);
      end
   end
`endif

   always_comb begin
      nib = snap[3:0];
      case (idx)
         DIG_SEC_TENS:  nib = snap[7:4];
         DIG_MIN_ONES:  nib = snap[11:8];
         DIG_MIN_TENS:  nib = snap[15:12];
         DIG_HOUR_ONES: nib = snap[19:16];
         DIG_HOUR_TENS: nib = snap[23:20];
         default:       nib = snap[3:0];
      endcase

      seg_nxt = bcd_to_seg(nib);
      if ((LZB != 0) && (idx == DIG_HOUR_TENS) && (nib == 4'd0)) begin
         seg_nxt = SEG_BLANK;
      end
`ifdef SEG7_SCAN_BLINK_EN
      // idx[2:1] maps digit pairs to fields: 0 = sec, 1 = min, 2 = hour.
      if (blink_phase && blink_mask[idx[2:1]]) begin
         seg_nxt = SEG_BLANK;
      end
`endif

      an_nxt = ~(6'b000001 << idx);
      dp_nxt = !((idx == DIG_MIN_ONES) || (idx == DIG_HOUR_ONES));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx  <= DIG_SEC_ONES;
         snap <= 24'h0;
         an   <= 6'b111111;
         seg  <= SEG_BLANK;
         dp   <= 1'b1;
      end else if (!en) begin
         idx  <= DIG_SEC_ONES;
         an   <= 6'b111111;
         seg  <= SEG_BLANK;
         dp   <= 1'b1;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
         dp  <= dp_nxt;
         if (tick) begin
            if (idx == DIG_HOUR_TENS) begin
               idx  <= DIG_SEC_ONES;
               snap <= {hour_bcd, min_bcd, sec_bcd};
            end else begin
               idx <= idx + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with CLK_HZ=600, SCAN_HZ=100 (6 cycles per digit).
// A reference model pushes the expected {an,seg,dp} each clock; scenario tasks
// pop one entry per cycle on the falling edge and also check literal values.
module tb_seg7_scan_driver;

   typedef struct packed {
      logic [5:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b1;
   logic [7:0] hour_bcd = 8'h00;
   logic [7:0] min_bcd  = 8'h00;
   logic [7:0] sec_bcd  = 8'h00;
   logic [5:0] an, an_nz;
   logic [6:0] seg, seg_nz;
   logic       dp, dp_nz;
`ifdef SEG7_SCAN_BLINK_EN
   logic [2:0] blink_mask = 3'b000;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   seg7_scan_driver #(.CLK_HZ(600), .SCAN_HZ(100), .LZB(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .hour_bcd   (hour_bcd),
      .min_bcd    (min_bcd),
      .sec_bcd    (sec_bcd),
`ifdef SEG7_SCAN_BLINK_EN
      .blink_mask (blink_mask),
`endif
      .an         (an),
      .seg        (seg),
      .dp         (dp)
   );

   seg7_scan_driver #(.CLK_HZ(600), .SCAN_HZ(100), .LZB(0)) dut_nz (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .hour_bcd   (hour_bcd),
      .min_bcd    (min_bcd),
      .sec_bcd    (sec_bcd),
`ifdef SEG7_SCAN_BLINK_EN
      .blink_mask (blink_mask),
`endif
      .an         (an_nz),
      .seg        (seg_nz),
      .dp         (dp_nz)
   );

   // Reference model (LZB=1 instance): computes this edge's output from the
   // pre-edge scan state, then advances the state.
   int          m_pre  = 0;
   int          m_idx  = 0;
   logic [23:0] m_snap = 24'h0;
   logic [6:0]  dec_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   always @(posedge clk) begin
      exp_t       e;
      logic [3:0] n;
      if (rst) begin
         e = {6'h3F, 7'h7F, 1'b1};
         m_pre = 0; m_idx = 0; m_snap = 24'h0;
      end else if (!en) begin
         e = {6'h3F, 7'h7F, 1'b1};
         m_pre = 0; m_idx = 0;
      end else begin
         n = m_snap[m_idx*4 +: 4];
         e.an = ~(6'd1 << m_idx);
         if (m_idx == 5 && n == 4'd0) e.seg = 7'h7F;
         else if (n > 4'd9)           e.seg = 7'h3F;
         else                         e.seg = dec_tab[n];
         e.dp = (m_idx == 2 || m_idx == 4) ? 1'b0 : 1'b1;
         if (m_pre == 5) begin
            if (m_idx == 5) m_snap = {hour_bcd, min_bcd, sec_bcd};
            m_idx = (m_idx + 1) % 6;
            m_pre = 0;
         end else begin
            m_pre++;
         end
      end
      sb_q.push_back(e);
   end

   // Advance one cycle and pop the model's entry for the edge just taken.
   // An empty queue yields X, which can never match the DUT.
   task automatic next_cycle(output exp_t e);
      @(negedge clk);
      if (sb_q.size() == 0) e = 'x;
      else                  e = sb_q.pop_front();
   endtask

   function automatic int an_to_idx(input logic [5:0] a);
      int k = -1;
      for (int j = 0; j < 6; j++) if (a == ~(6'd1 << j)) k = j;
      return k;
   endfunction

   task automatic test_reset();
      exp_t       e;
      logic [5:0] walk [7] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h3E};
      rst = 1'b1; en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_cycle(e);
         total_cnt++;
         if ({an, seg, dp} !== {6'h3F, 7'h7F, 1'b1})
            $display("FAIL reset_vals: got an=%h seg=%h dp=%b want an=3f seg=7f dp=1", an, seg, dp);
         else pass_cnt++;
      end
      rst = 1'b0;
      for (int c = 0; c < 42; c++) begin
         next_cycle(e);
         total_cnt++;
         if ({an, seg, dp} !== e)
            $display("FAIL reset_sb c=%0d: got %h/%h/%b want %h/%h/%b", c, an, seg, dp, e.an, e.seg, e.dp);
         else pass_cnt++;
         total_cnt++;
         if (an !== walk[c/6])
            $display("FAIL reset_walk c=%0d: got an=%h want %h", c, an, walk[c/6]);
         else pass_cnt++;
      end
   endtask

   task automatic test_static();
      exp_t       e;
      int         k;
      logic [6:0] lit [6] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
      hour_bcd = 8'h12; min_bcd = 8'h34; sec_bcd = 8'h56;
      for (int c = 0; c < 108; c++) begin
         next_cycle(e);
         total_cnt++;
         if ({an, seg, dp} !== e)
            $display("FAIL static_sb c=%0d: got %h/%h/%b want %h/%h/%b", c, an, seg, dp, e.an, e.seg, e.dp);
         else pass_cnt++;
         if (c >= 72) begin
            k = an_to_idx(an);
            total_cnt++;
            if (k < 0 || seg !== lit[k] || dp !== ((k == 2 || k == 4) ? 1'b0 : 1'b1))
               $display("FAIL static_lit c=%0d: got an=%h seg=%h dp=%b", c, an, seg, dp);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_tear_free();
      exp_t e;
      bit   found = 0;
      bit   frame1 = 0;
      hour_bcd = 8'h12; min_bcd = 8'h34; sec_bcd = 8'h59;
      for (int c = 0; c < 72; c++) begin
         next_cycle(e);
         total_cnt++;
         if ({an, seg, dp} !== e)
            $display("FAIL tear_sb c=%0d: got %h/%h/%b want %h/%h/%b", c, an, seg, dp, e.an, e.seg, e.dp);
         else pass_cnt++;
      end
      for (int c = 0; c < 40 && !found; c++) begin
         next_cycle(e);
         total_cnt++;
         if ({an, seg, dp} !== e)
            $display("FAIL tear_sb2 c=%0d: got %h/%h/%b want %h/%h/%b", c, an, seg, dp, e.an, e.seg, e.dp);
         else pass_cnt++;
         if (an === 6'h3B) found = 1;
      end
      total_cnt++;
      if (!found) $display("FAIL tear_wait: got no idx2 want an=3b within 40 cycles");
      else pass_cnt++;
      sec_bcd = 8'h00; hour_bcd = 8'h23;
      for (int c = 0; c < 66; c++) begin
         next_cycle(e);
         total_cnt++;
         if ({an, seg, dp} !== e)
            $display("FAIL tear_sb3 c=%0d: got %h/%h/%b want %h/%h/%b", c, an, seg, dp, e.an, e.seg, e.dp);
         else pass_cnt++;
         if (an === 6'h3E) frame1 = 1;
         if (!frame1) begin
            if (an === 6'h37) begin total_cnt++; if (seg !== 7'h30) $display("FAIL tear_old_mt: got %h want 30", seg); else pass_cnt++; end
            if (an === 6'h2F) begin total_cnt++; if (seg !== 7'h24) $display("FAIL tear_old_ho: got %h want 24", seg); else pass_cnt++; end
            if (an === 6'h1F) begin total_cnt++; if (seg !== 7'h79) $display("FAIL tear_old_ht: got %h want 79", seg); else pass_cnt++; end
         end else begin
            if (an === 6'h3E) begin total_cnt++; if (seg !== 7'h40) $display("FAIL tear_new_so: got %h want 40", seg); else pass_cnt++; end
            if (an === 6'h3D) begin total_cnt++; if (seg !== 7'h40) $display("FAIL tear_new_st: got %h want 40", seg); else pass_cnt++; end
            if (an === 6'h2F) begin total_cnt++; if (seg !== 7'h30) $display("FAIL tear_new_ho: got %h want 30", seg); else pass_cnt++; end
            if (an === 6'h1F) begin total_cnt++; if (seg !== 7'h24) $display("FAIL tear_new_ht: got %h want 24", seg); else pass_cnt++; end
         end
      end
      total_cnt++;
      if (!frame1) $display("FAIL tear_frame: got no new frame want an=3e");
      else pass_cnt++;
   endtask

   task automatic test_invalid_lzb();
      exp_t e;
      hour_bcd = 8'h0A; min_bcd = 8'h00; sec_bcd = 8'h00;
      for (int c = 0; c < 84; c++) begin
         next_cycle(e);
         total_cnt++;
         if ({an, seg, dp} !== e)
            $display("FAIL inv_sb c=%0d: got %h/%h/%b want %h/%h/%b", c, an, seg, dp, e.an, e.seg, e.dp);
         else pass_cnt++;
         if (c >= 42) begin
            total_cnt++;
            if ({an_nz, dp_nz} !== {an, dp})
               $display("FAIL inv_nz_an: got an=%h dp=%b want an=%h dp=%b", an_nz, dp_nz, an, dp);
            else pass_cnt++;
            if (an === 6'h2F) begin
               total_cnt++;
               if (seg !== 7'h3F) $display("FAIL inv_dash: got %h want 3f", seg); else pass_cnt++;
            end
            if (an === 6'h1F) begin
               total_cnt++;
               if (seg !== 7'h7F) $display("FAIL lzb_on: got %h want 7f", seg); else pass_cnt++;
               total_cnt++;
               if (seg_nz !== 7'h40) $display("FAIL lzb_off: got %h want 40", seg_nz); else pass_cnt++;
            end
         end
      end
   endtask

   task automatic test_enable();
      exp_t e;
      bit   found = 0;
      hour_bcd = 8'h12; min_bcd = 8'h34; sec_bcd = 8'h56;
      for (int c = 0; c < 80; c++) begin
         next_cycle(e);
         total_cnt++;
         if ({an, seg, dp} !== e)
            $display("FAIL en_sb c=%0d: got %h/%h/%b want %h/%h/%b", c, an, seg, dp, e.an, e.seg, e.dp);
         else pass_cnt++;
      end
      for (int c = 0; c < 40 && !found; c++) begin
         next_cycle(e);
         total_cnt++;
         if ({an, seg, dp} !== e)
            $display("FAIL en_sb2 c=%0d: got %h/%h/%b want %h/%h/%b", c, an, seg, dp, e.an, e.seg, e.dp);
         else pass_cnt++;
         if (an === 6'h37) found = 1;
      end
      total_cnt++;
      if (!found) $display("FAIL en_wait: got no idx3 want an=37 within 40 cycles");
      else pass_cnt++;
      en = 1'b0;
      for (int c = 0; c < 4; c++) begin
         next_cycle(e);
         if (c == 1) sec_bcd = 8'h11;
         total_cnt++;
         if ({an, seg, dp} !== {6'h3F, 7'h7F, 1'b1})
            $display("FAIL en_off c=%0d: got an=%h seg=%h dp=%b want 3f/7f/1", c, an, seg, dp);
         else pass_cnt++;
         total_cnt++;
         if ({an, seg, dp} !== e)
            $display("FAIL en_off_sb c=%0d: got %h/%h/%b want %h/%h/%b", c, an, seg, dp, e.an, e.seg, e.dp);
         else pass_cnt++;
      end
      en = 1'b1;
      for (int c = 0; c < 12; c++) begin
         next_cycle(e);
         total_cnt++;
         if ({an, seg, dp} !== e)
            $display("FAIL en_on_sb c=%0d: got %h/%h/%b want %h/%h/%b", c, an, seg, dp, e.an, e.seg, e.dp);
         else pass_cnt++;
         total_cnt++;
         if (an !== ((c < 6) ? 6'h3E : 6'h3D))
            $display("FAIL en_restart c=%0d: got an=%h want %h", c, an, (c < 6) ? 6'h3E : 6'h3D);
         else pass_cnt++;
         if (c < 6) begin
            total_cnt++;
            if (seg !== 7'h02) $display("FAIL en_old_snap c=%0d: got %h want 02", c, seg);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      bit   found = 0;
      for (int c = 0; c < 40 && !found; c++) begin
         next_cycle(e);
         total_cnt++;
         if ({an, seg, dp} !== e)
            $display("FAIL rmid_sb c=%0d: got %h/%h/%b want %h/%h/%b", c, an, seg, dp, e.an, e.seg, e.dp);
         else pass_cnt++;
         if (an === 6'h37) found = 1;
      end
      total_cnt++;
      if (!found) $display("FAIL rmid_wait: got no idx3 want an=37 within 40 cycles");
      else pass_cnt++;
      rst = 1'b1;
      next_cycle(e);
      rst = 1'b0;
      total_cnt++;
      if ({an, seg, dp} !== {6'h3F, 7'h7F, 1'b1})
         $display("FAIL rmid_vals: got an=%h seg=%h dp=%b want 3f/7f/1", an, seg, dp);
      else pass_cnt++;
      for (int c = 0; c < 36; c++) begin
         next_cycle(e);
         total_cnt++;
         if ({an, seg, dp} !== e)
            $display("FAIL rmid_sb2 c=%0d: got %h/%h/%b want %h/%h/%b", c, an, seg, dp, e.an, e.seg, e.dp);
         else pass_cnt++;
         if (an === 6'h3E || an === 6'h3D) begin
            total_cnt++;
            if (seg !== 7'h40) $display("FAIL rmid_zero c=%0d: got %h want 40", c, seg); else pass_cnt++;
         end
         if (an === 6'h1F) begin
            total_cnt++;
            if (seg !== 7'h7F) $display("FAIL rmid_lzb c=%0d: got %h want 7f", c, seg); else pass_cnt++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_static();
      test_tear_free();
      test_invalid_lzb();
      test_enable();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
